pc_trace_fifo: RTL
==================

Name: pc_trace_fifo

Overview:
Parametrised program-counter trace buffer that follows the single 32-bit pc_out signal. It samples the core's PC stream and stores samples in a DEPTH-entry FIFO. Two capture modes: every PC, or only control-flow discontinuities. The FIFO is drained through a valid/ready port by the debug/trace logic or the bench scoreboard.

Parameters:
PC_WIDTH, 32, width of captured PC.
DEPTH, 16, FIFO entries; power of 2, minimum 2.
INSTR_BYTES, 4, sequential PC increment used for discontinuity detection.
CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous reset, active-high: 1 = in reset, despite the suffix.
clear  in  1  synchronous flush of FIFO, counters and history.
enable  in  1  capture enable.
mode  in  1  0 = capture every valid PC; 1 = capture discontinuities only.
pc_valid  in  1  pc_in is a retired/fetched PC this cycle.
pc_in  in  PC_WIDTH  PC sample.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer accepts head.
out_pc  out  PC_WIDTH  head PC.
out_jump  out  1  head entry was a discontinuity.
level  out  $clog2(DEPTH)+1  current occupancy.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
overflow  out  1  sticky: at least one sample dropped since reset/clear.
drop_cnt  out  CNT_WIDTH  dropped samples, saturating at all-ones.

Behaviour:
- Reset (rst_n = 1, async):
  - out_valid=0, out_pc=0, out_jump=0, level=0, full=0, empty=1, overflow=0, drop_cnt=0.
  - Pointers = 0, last_pc = 0, first flag = 1.
- Sample accepted: pc_valid && enable.
  - Always updates last_pc <= pc_in and clears first flag, whether or not it is captured.
- Discontinuity (jump): first flag set, OR pc_in != last_pc + INSTR_BYTES.
  - Addition is modulo 2^PC_WIDTH, so last_pc = 0xFFFF_FFFC followed by 0x0000_0000 is sequential.
- First flag is set by reset, by clear, and by an enable 0->1 transition.
- Push request:
  - mode=0: on every accepted sample.
  - mode=1: only on an accepted sample that is a jump.
- Stored entry = {pc_in, jump}.
- Pop: out_valid && out_ready.
- Push accepted when !full, or when full and a pop occurs in the same cycle.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- Push rejected (full, no pop):
  - Sample dropped, overflow <= 1.
  - drop_cnt increments, holding at 2^CNT_WIDTH-1.
  - FIFO contents untouched.
- Latency and head stability:
  - An entry pushed into an empty FIFO drives out_valid=1 on the next cycle; no same-cycle fall-through.
  - out_pc/out_jump show the head (show-ahead) and stay stable while out_valid && !out_ready.
- Pop on empty is impossible because out_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is held as an explicit counter; full/empty/out_valid are derived from it and registered consistently.
- clear (synchronous, highest priority):
  - Same-cycle push and pop are ignored.
  - Next cycle: level=0, out_valid=0, overflow=0, drop_cnt=0, first flag=1.
  - Storage RAM contents need not be cleared.
- enable=0: no pushes and no last_pc update; draining continues normally.
- Reset asserted mid-drain: all state returns to reset values immediately; in-flight head is lost.

Test Plan:
1. mode=0, DEPTH=16: push PCs 0x100, 0x104, 0x108 with out_ready=0 -> level=3; then out_ready=1 -> out_pc 0x100 (jump=1), 0x104 (jump=0), 0x108 (jump=0) on consecutive cycles; empty=1 after.
2. mode=1: PCs 0x100, 0x104, 0x200, 0x204, 0x0FC -> exactly 0x100, 0x200, 0x0FC stored, all jump=1; level=3.
3. Overflow: mode=0, out_ready=0, 20 sequential PCs -> full=1, level=16, overflow=1, drop_cnt=4; drain yields the first 16 PCs in order.
4. Full plus simultaneous pop and push: 17th PC pushed while out_ready=1 -> accepted, level stays 16, drop_cnt=0.
5. Wrap: last_pc=0xFFFFFFFC then pc_in=0x00000000 in mode=1 -> no push; then enable toggled 0->1 with pc_in=0x4 -> pushed with jump=1.
6. clear asserted with level=5, drop_cnt=3, and pc_valid=1 in the same cycle -> next cycle level=0, out_valid=0, drop_cnt=0, overflow=0; next valid PC is captured with jump=1. Async reset mid-drain -> all outputs reset in the same cycle.

Source files
------------

// File: rtl/pc_trace_fifo_if.sv
// pc_trace_fifo_if
// Purpose : valid/ready drain port of the PC trace buffer.
// Signals : out_valid - head entry present
//           out_ready - consumer accepts the head this cycle
//           out_pc    - PC stored in the head entry
//           out_jump  - head entry was a control-flow discontinuity
// Modports: master = the trace FIFO (drives the head), slave = the consumer.
interface pc_trace_fifo_if #(
    parameter int PC_WIDTH = 32
);
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic                out_jump;

    modport master (output out_valid, output out_pc, output out_jump, input out_ready);
    modport slave  (input out_valid, input out_pc, input out_jump, output out_ready);
endinterface

// File: rtl/pc_trace_fifo.sv
// pc_trace_fifo
// Purpose : follows the core's PC stream and buffers samples in a DEPTH-entry
//           show-ahead FIFO. mode=0 stores every accepted PC, mode=1 stores
//           only control-flow discontinuities. Every entry carries a jump bit.
// Ports   : clk       - rising-edge clock
//           rst_n     - asynchronous reset, ACTIVE HIGH despite the suffix
//           clear     - synchronous flush of FIFO, drop counters and history
//           enable    - capture enable
//           mode      - 0 = every PC, 1 = discontinuities only
//           pc_valid  - pc_in carries a PC this cycle
//           pc_in     - PC sample
//           out_if    - drain port (valid/ready, head PC and jump flag)
//           level     - occupancy
//           full      - level == DEPTH
//           empty     - level == 0
//           overflow  - sticky, a sample was dropped since reset/clear
//           drop_cnt  - saturating count of dropped samples
module pc_trace_fifo #(
    parameter int PC_WIDTH    = 32,
    parameter int DEPTH       = 16,
    parameter int INSTR_BYTES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     pc_valid,
    input  logic [PC_WIDTH-1:0]      pc_in,
    pc_trace_fifo_if.master          out_if,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_cnt
);

    localparam int                  PTR_W   = $clog2(DEPTH);
    localparam int                  LVL_W   = PTR_W + 1;
    localparam logic [LVL_W-1:0]    DEPTH_L = LVL_W'(DEPTH);
    localparam logic [PC_WIDTH-1:0] STEP    = PC_WIDTH'(INSTR_BYTES);

    // Each entry is {pc, jump}
    logic [PC_WIDTH:0]     mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_next;
    logic                  valid_q;
    logic                  full_q;
    logic                  empty_q;
    logic [PC_WIDTH-1:0]   last_pc;
    logic                  first_flag;
    logic                  enable_q;
    logic                  overflow_q;
    logic [CNT_WIDTH-1:0]  drop_q;

    logic enable_rise;
    logic accept;
    logic is_jump;
    logic push_req;
    logic pop;
    logic push_ok;
    logic drop;

    // A rising enable restarts the history, so the very sample that arrives
    // with it must already count as a jump; hence enable_rise joins first_flag
    // here instead of waiting for first_flag to be registered.
    // The sequential check wraps modulo 2^PC_WIDTH by plain truncation.
    always_comb begin
        enable_rise = enable & ~enable_q;
        accept      = pc_valid & enable;
        is_jump     = first_flag | enable_rise | (pc_in != last_pc + STEP);
        push_req    = accept & (~mode | is_jump);
        pop         = valid_q & out_if.out_ready;
        push_ok     = push_req & (~full_q | pop);
        drop        = push_req & full_q & ~pop;
    end

    // Occupancy bookkeeping; clear overrides any same-cycle push/pop.
    always_comb begin
        level_next = level_q;
        if (clear) begin
            level_next = '0;
        end else if (push_ok && !pop) begin
            level_next = level_q + LVL_W'(1);
        end else if (pop && !push_ok) begin
            level_next = level_q - LVL_W'(1);
        end
    end

    // Control state. valid/full/empty are registered from level_next so they
    // always agree with level in the same cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            last_pc    <= '0;
            first_flag <= 1'b1;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            enable_q <= enable;
            level_q  <= level_next;
            valid_q  <= (level_next != '0);
            full_q   <= (level_next == DEPTH_L);
            empty_q  <= (level_next == '0);
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                last_pc    <= '0;
                first_flag <= 1'b1;
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (accept) begin
                    last_pc    <= pc_in;
                    first_flag <= 1'b0;
                end else if (enable_rise) begin
                    first_flag <= 1'b1;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                    if (drop_q != '1) begin
                        drop_q <= drop_q + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!clear && push_ok) begin
            mem[wr_ptr] <= {pc_in, is_jump};
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_pc    = valid_q ? mem[rd_ptr][PC_WIDTH:1] : '0;
    assign out_if.out_jump  = valid_q & mem[rd_ptr][0];
    assign level            = level_q;
    assign full             = full_q;
    assign empty            = empty_q;
    assign overflow         = overflow_q;
    assign drop_cnt         = drop_q;

endmodule
